// File: rtl/cpu_if_arb_pkg.sv
// cpu_if_arb_pkg: shared types and helpers for the cpu_if arbiter.
//   MAX_CPU / ID_MAX_W : upper bound on master count and stored ID width.
//   fifo_entry_t       : in-flight entry {master id, is_wr}.
//   id_width()         : ID width for a given master count ($clog2, min 1).
//   rr_pick()          : round-robin pick of the first requester at or after ptr.
package cpu_if_arb_pkg;

    localparam int unsigned MAX_CPU  = 64;
    localparam int unsigned ID_MAX_W = 6;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic                is_wr;
    } fifo_entry_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Returns 0 when nothing is requesting; callers gate on "any request".
    function automatic logic [ID_MAX_W-1:0] rr_pick(input logic [MAX_CPU-1:0] req,
                                                    input logic [ID_MAX_W-1:0] ptr,
                                                    input int unsigned         n);
        logic [ID_MAX_W-1:0] pick;
        logic                found;
        int unsigned         idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < MAX_CPU; off++) begin
            if (off < n) begin
                idx = 32'(ptr) + off;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx[ID_MAX_W-1:0]]) begin
                    found = 1'b1;
                    pick  = idx[ID_MAX_W-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cpu_if_arb_fifo.sv
// cpu_if_arb_fifo: in-order FIFO of in-flight {id, is_wr} entries.
//   clk, reset (async, active-low)
//   push/push_data : enqueue; honoured when not full, or when full with a pop
//   pop            : dequeue head (ignored when empty)
//   head           : current head entry
//   full / empty   : occupancy flags
module cpu_if_arb_fifo
    import cpu_if_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fifo_entry_t     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CntW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/cpu_if_arbiter.sv
// cpu_if_arbiter: round-robin N-to-1 merge of cpu_if register masters onto one device port,
// with up to OUTSTANDING in-order transactions in flight and ack routing back to the issuer.
//   clk, reset (async, active-low)
//   m_*          : per-master request fields in, stalls/acks/errs/read data out (slice i = master i)
//   d_*          : device request out, device stalls/acks/errs/read data in
//   spurious_ack : sticky, set when an ack arrives with nothing in flight
// Optional: define CPU_IF_ARB_TIMEOUT_EN to complete a stuck head with an error after
// TIMEOUT_CYCLES cycles; the late device acks are then discarded via drop_cnt.
module cpu_if_arbiter
    import cpu_if_arb_pkg::*;
#(
    parameter int unsigned NUM_CPU        = 2,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned OUTSTANDING    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CPU-1:0]               m_req,
    input  logic [NUM_CPU-1:0]               m_req_is_wr,
    input  logic [NUM_CPU*ADDR_WIDTH-1:0]    m_addr,
    input  logic [NUM_CPU*DATA_WIDTH-1:0]    m_wr_data,
    input  logic [NUM_CPU*DATA_WIDTH-1:0]    m_wr_biten,
    output logic [NUM_CPU-1:0]               m_req_stall_wr,
    output logic [NUM_CPU-1:0]               m_req_stall_rd,
    output logic [NUM_CPU-1:0]               m_rd_ack,
    output logic [NUM_CPU-1:0]               m_rd_err,
    output logic [NUM_CPU-1:0]               m_wr_ack,
    output logic [NUM_CPU-1:0]               m_wr_err,
    output logic [NUM_CPU*DATA_WIDTH-1:0]    m_rd_data,
    output logic                             d_req,
    output logic                             d_req_is_wr,
    output logic [ADDR_WIDTH-1:0]            d_addr,
    output logic [DATA_WIDTH-1:0]            d_wr_data,
    output logic [DATA_WIDTH-1:0]            d_wr_biten,
    input  logic                             d_req_stall_wr,
    input  logic                             d_req_stall_rd,
    input  logic                             d_rd_ack,
    input  logic                             d_rd_err,
    input  logic [DATA_WIDTH-1:0]            d_rd_data,
    input  logic                             d_wr_ack,
    input  logic                             d_wr_err,
    output logic                             spurious_ack
);

    localparam int unsigned IdW = id_width(NUM_CPU);

    logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
    logic                spurious_q, spurious_d;
    logic [MAX_CPU-1:0]  req_ext;
    logic [ID_MAX_W-1:0] grant;
    logic                any_req, accept;
    logic                dev_ack, dev_pop, tmo_pop, pop, spurious_hit;
    logic                fifo_full, fifo_empty;
    fifo_entry_t         head, push_entry;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_CPU-1:0] = m_req;
    end

    assign any_req = |m_req;
    assign grant   = rr_pick(req_ext, ID_MAX_W'(rr_ptr_q), NUM_CPU);

    // Request mux: granted master's fields onto the device port.
    always_comb begin
        d_req_is_wr = 1'b0;
        d_addr      = '0;
        d_wr_data   = '0;
        d_wr_biten  = '0;
        for (int unsigned i = 0; i < NUM_CPU; i++) begin
            if (grant == ID_MAX_W'(i)) begin
                d_req_is_wr = m_req_is_wr[i];
                d_addr      = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                d_wr_data   = m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                d_wr_biten  = m_wr_biten[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Gated by reset so the device port stays idle while reset is held.
    assign d_req  = reset && any_req && (!fifo_full || pop);
    assign accept = d_req && (d_req_is_wr ? !d_req_stall_wr : !d_req_stall_rd);
    assign dev_ack = d_rd_ack || d_wr_ack;
    assign pop     = dev_pop || tmo_pop;

`ifdef CPU_IF_ARB_TIMEOUT_EN
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DropW = $clog2(OUTSTANDING + 1);

    logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [DropW-1:0] drop_cnt_q, drop_cnt_d;
    logic             dev_drop;

    // Acks owed by the device for timed-out entries are swallowed first.
    assign dev_drop     = dev_ack && (drop_cnt_q != '0);
    assign dev_pop      = dev_ack && !dev_drop && !fifo_empty;
    assign spurious_hit = dev_ack && !dev_drop && fifo_empty;
    assign tmo_pop      = !fifo_empty && !dev_pop && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d  = '0;
        drop_cnt_d = drop_cnt_q;
        if (!pop && !fifo_empty) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        if (tmo_pop && !dev_drop && (drop_cnt_q != DropW'(OUTSTANDING))) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end else if (dev_drop && !tmo_pop) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
`else
    assign dev_pop      = dev_ack && !fifo_empty;
    assign spurious_hit = dev_ack && fifo_empty;
    assign tmo_pop      = 1'b0;
`endif

    assign push_entry = '{id: grant, is_wr: d_req_is_wr};

    cpu_if_arb_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Per-master stalls and completion routing to the head master.
    always_comb begin
        m_req_stall_wr = '1;
        m_req_stall_rd = '1;
        m_rd_ack       = '0;
        m_rd_err       = '0;
        m_wr_ack       = '0;
        m_wr_err       = '0;
        m_rd_data      = '0;
        for (int unsigned i = 0; i < NUM_CPU; i++) begin
            if (accept && (grant == ID_MAX_W'(i))) begin
                m_req_stall_wr[i] = 1'b0;
                m_req_stall_rd[i] = 1'b0;
            end
            if (head.id == ID_MAX_W'(i)) begin
                if (dev_pop) begin
                    // Ack type follows the device even if it disagrees with head.is_wr.
                    m_rd_ack[i]                         = d_rd_ack;
                    m_rd_err[i]                         = d_rd_ack && d_rd_err;
                    m_wr_ack[i]                         = d_wr_ack;
                    m_wr_err[i]                         = d_wr_ack && d_wr_err;
                    m_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = d_rd_data;
                end else if (tmo_pop) begin
                    m_rd_ack[i] = !head.is_wr;
                    m_rd_err[i] = !head.is_wr;
                    m_wr_ack[i] = head.is_wr;
                    m_wr_err[i] = head.is_wr;
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        spurious_d = spurious_q || spurious_hit;
        if (accept) begin
            rr_ptr_d = (grant == ID_MAX_W'(NUM_CPU - 1)) ? '0 : IdW'(grant + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            spurious_q <= spurious_d;
        end
    end

    assign spurious_ack = spurious_q;

endmodule

// File: tb/tb_cpu_if_arbiter.sv
// Scoreboard bench for cpu_if_arbiter (NUM_CPU=2, OUTSTANDING=2, TIMEOUT_CYCLES=8).
// Each accepted request pushes its expected completion; each ack pops and compares routing.
module tb_cpu_if_arbiter;

    localparam int unsigned NCPU = 2;
    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 16;
    localparam int unsigned OUTS = 2;
    localparam int unsigned TMO  = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCPU-1:0]      m_req, m_req_is_wr;
    logic [NCPU*AW-1:0]   m_addr;
    logic [NCPU*DW-1:0]   m_wr_data, m_wr_biten;
    logic [NCPU-1:0]      m_req_stall_wr, m_req_stall_rd;
    logic [NCPU-1:0]      m_rd_ack, m_rd_err, m_wr_ack, m_wr_err;
    logic [NCPU*DW-1:0]   m_rd_data;
    logic                 d_req, d_req_is_wr;
    logic [AW-1:0]        d_addr;
    logic [DW-1:0]        d_wr_data, d_wr_biten;
    logic                 d_req_stall_wr, d_req_stall_rd;
    logic                 d_rd_ack, d_rd_err, d_wr_ack, d_wr_err;
    logic [DW-1:0]        d_rd_data;
    logic                 spurious_ack;

    logic [AW-1:0] addr_v  [NCPU];
    logic [DW-1:0] wdata_v [NCPU];
    logic [DW-1:0] biten_v [NCPU];

    always_comb begin
        m_addr     = '0;
        m_wr_data  = '0;
        m_wr_biten = '0;
        for (int i = 0; i < NCPU; i++) begin
            m_addr[i*AW +: AW]     = addr_v[i];
            m_wr_data[i*DW +: DW]  = wdata_v[i];
            m_wr_biten[i*DW +: DW] = biten_v[i];
        end
    end

    always #5 clk = ~clk;

    cpu_if_arbiter #(
        .NUM_CPU        (NCPU),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .OUTSTANDING    (OUTS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .m_req          (m_req),
        .m_req_is_wr    (m_req_is_wr),
        .m_addr         (m_addr),
        .m_wr_data      (m_wr_data),
        .m_wr_biten     (m_wr_biten),
        .m_req_stall_wr (m_req_stall_wr),
        .m_req_stall_rd (m_req_stall_rd),
        .m_rd_ack       (m_rd_ack),
        .m_rd_err       (m_rd_err),
        .m_wr_ack       (m_wr_ack),
        .m_wr_err       (m_wr_err),
        .m_rd_data      (m_rd_data),
        .d_req          (d_req),
        .d_req_is_wr    (d_req_is_wr),
        .d_addr         (d_addr),
        .d_wr_data      (d_wr_data),
        .d_wr_biten     (d_wr_biten),
        .d_req_stall_wr (d_req_stall_wr),
        .d_req_stall_rd (d_req_stall_rd),
        .d_rd_ack       (d_rd_ack),
        .d_rd_err       (d_rd_err),
        .d_rd_data      (d_rd_data),
        .d_wr_ack       (d_wr_ack),
        .d_wr_err       (d_wr_err),
        .spurious_ack   (spurious_ack)
    );

    typedef struct {
        int   id;
        logic is_wr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cnt_m    = 0;
    int   rr_m     = 0;
    int   drop_m   = 0;
    int   tmo_m    = 0;
    logic spur_m   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One clock cycle: drive at negedge, compare 1 time unit later, update the model.
    task automatic step(input logic [1:0] req, input logic [1:0] wr, input logic rd_ack,
                        input logic wr_ack, input logic [15:0] rdata, input logic err,
                        input logic stall);
        logic [1:0]  e_rd_ack, e_rd_err, e_wr_ack, e_wr_err, e_stall;
        logic [31:0] e_rdata;
        logic        pop, dreq, acc, spur_next;
        int          g, cnt_before;
        exp_t        e;
        @(negedge clk);
        m_req          = req;
        m_req_is_wr    = wr;
        d_rd_ack       = rd_ack;
        d_wr_ack       = wr_ack;
        d_rd_data      = rdata;
        d_rd_err       = err;
        d_wr_err       = err;
        d_req_stall_wr = stall;
        d_req_stall_rd = stall;
        #1;
        e_rd_ack = '0; e_rd_err = '0; e_wr_ack = '0; e_wr_err = '0;
        e_rdata  = '0;
        pop = 1'b0; spur_next = 1'b0;
        cnt_before = cnt_m;
        if ((rd_ack || wr_ack) && drop_m > 0) begin
            drop_m--;
        end else if ((rd_ack || wr_ack) && cnt_m == 0) begin
            spur_next = 1'b1;
        end else if (rd_ack || wr_ack) begin
            e = sb.pop_front();
            e_rd_ack[e.id] = rd_ack;
            e_rd_err[e.id] = rd_ack & err;
            e_wr_ack[e.id] = wr_ack;
            e_wr_err[e.id] = wr_ack & err;
            e_rdata[e.id*16 +: 16] = rdata;
            pop = 1'b1;
        end
`ifdef CPU_IF_ARB_TIMEOUT_EN
        if (!pop && cnt_m > 0 && tmo_m == TMO - 1) begin
            e = sb.pop_front();
            e_rd_ack[e.id] = !e.is_wr;
            e_rd_err[e.id] = !e.is_wr;
            e_wr_ack[e.id] = e.is_wr;
            e_wr_err[e.id] = e.is_wr;
            pop = 1'b1;
            drop_m++;
        end
`endif
        dreq = (req != 2'b00) && (cnt_m < OUTS || pop);
        g = rr_m;
        for (int k = 0; k < NCPU; k++) begin
            if (req[(rr_m + k) % NCPU]) begin
                g = (rr_m + k) % NCPU;
                break;
            end
        end
        acc = dreq && !stall;
        e_stall = 2'b11;
        if (acc) e_stall[g] = 1'b0;
        check_eq("d_req", {31'd0, d_req}, {31'd0, dreq});
        check_eq("stall_wr", {30'd0, m_req_stall_wr}, {30'd0, e_stall});
        check_eq("stall_rd", {30'd0, m_req_stall_rd}, {30'd0, e_stall});
        check_eq("rd_ack", {30'd0, m_rd_ack}, {30'd0, e_rd_ack});
        check_eq("rd_err", {30'd0, m_rd_err}, {30'd0, e_rd_err});
        check_eq("wr_ack", {30'd0, m_wr_ack}, {30'd0, e_wr_ack});
        check_eq("wr_err", {30'd0, m_wr_err}, {30'd0, e_wr_err});
        if (pop) check_eq("rd_data", m_rd_data, e_rdata);
        check_eq("spurious", {31'd0, spurious_ack}, {31'd0, spur_m});
        if (dreq) begin
            check_eq("d_addr", {16'd0, d_addr}, {16'd0, addr_v[g]});
            check_eq("d_is_wr", {31'd0, d_req_is_wr}, {31'd0, wr[g]});
            check_eq("d_wr_data", {16'd0, d_wr_data}, {16'd0, wdata_v[g]});
            check_eq("d_biten", {16'd0, d_wr_biten}, {16'd0, biten_v[g]});
        end
        if (acc) begin
            sb.push_back('{id: g, is_wr: wr[g]});
            rr_m = (g + 1) % NCPU;
        end
        cnt_m = cnt_m - (pop ? 1 : 0) + (acc ? 1 : 0);
        tmo_m = pop ? 0 : ((cnt_before > 0) ? tmo_m + 1 : 0);
        spur_m = spur_m | spur_next;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_d_req", {31'd0, d_req}, 32'd0);
        check_eq("rst_stall_wr", {30'd0, m_req_stall_wr}, 32'd3);
        check_eq("rst_stall_rd", {30'd0, m_req_stall_rd}, 32'd3);
        check_eq("rst_acks", {24'd0, m_rd_ack, m_rd_err, m_wr_ack, m_wr_err}, 32'd0);
        check_eq("rst_rd_data", m_rd_data, 32'd0);
        check_eq("rst_spurious", {31'd0, spurious_ack}, 32'd0);
    endtask

    task automatic model_reset();
        sb.delete();
        cnt_m = 0; rr_m = 0; drop_m = 0; tmo_m = 0; spur_m = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NCPU; i++) begin
            addr_v[i]  = 16'h0100 + 16'(i);
            wdata_v[i] = 16'hA000 + 16'(i);
            biten_v[i] = 16'hFF00 ^ 16'(i);
        end
        addr_v[1] = 16'h0010;
        reset = 1'b0;
        m_req = 2'b11; m_req_is_wr = 2'b00;
        d_rd_ack = 1'b1; d_wr_ack = 1'b0; d_rd_err = 1'b0; d_wr_err = 1'b0;
        d_rd_data = 16'h5555; d_req_stall_wr = 1'b0; d_req_stall_rd = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        m_req = 2'b00; d_rd_ack = 1'b0;
        reset = 1'b1;

        // Single read from m1 only.
        step(2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);

        // Both masters always requesting: alternating grants, acks routed back.
        step(2'b11, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(2'b11, 2'b00, 1'b1, 1'b0, 16'h1000 + 16'(k), (k == 2), 1'b0);
        end
        step(2'b11, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step(2'b00, 2'b00, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0);

        // Fill to OUTSTANDING, third request stalls, ack+request keeps it full.
        step(2'b11, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(2'b11, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(2'b11, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(2'b11, 2'b10, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b1, 1'b0, 16'h3333, 1'b0, 1'b0);

`ifdef CPU_IF_ARB_TIMEOUT_EN
        // Write from m0 never acked: error completion on the 8th cycle, late ack dropped.
        step(2'b01, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        end
        step(2'b00, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
`endif

        // Reset with two in flight, then a fresh request is taken at once.
        step(2'b11, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(2'b11, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        m_req = 2'b11;
        d_rd_ack = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        m_req = 2'b00; d_rd_ack = 1'b0;
        reset = 1'b1;
        model_reset();
        step(2'b01, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b1, 1'b0, 16'h4444, 1'b0, 1'b0);

        // Ack with nothing in flight: discarded, sticky flag.
        step(2'b00, 2'b00, 1'b1, 1'b0, 16'h7777, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(2'b10, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_if_arbiter.md
# cpu_if_arbiter

- Parametrised N-to-1 arbiter that merges several CPU register-access masters onto one `cpu_if`-style device port.
- Masters are, for example, the SPI/UART command bridge and the on-chip sequencer; the device is the register block.
- The arbiter picks one master per cycle in round-robin order and allows up to OUTSTANDING in-order transactions in flight.
- It routes each rd/wr ack back to the master that issued the request.

## Interface
Parameters:
- NUM_CPU, 2: number of master ports, ≥2.
- ADDR_WIDTH, 16: address width.
- DATA_WIDTH, 16: data and bit-enable width.
- OUTSTANDING, 4: depth of the in-flight ID FIFO, ≥1.
- TIMEOUT_CYCLES, 256: ack timeout. Used only when the timeout macro is defined.

Ports:
- clk  in  1  the single clock.
- reset  in  1  asynchronous, active-low reset.
- m_req / m_req_is_wr  in  NUM_CPU  per-master request and write flag.
- m_addr  in  NUM_CPU*ADDR_WIDTH  per-master address; master i uses slice i.
- m_wr_data / m_wr_biten  in  NUM_CPU*DATA_WIDTH  per-master write data and bit enables.
- m_req_stall_wr / m_req_stall_rd  out  NUM_CPU  per-master stall.
- m_rd_ack / m_rd_err / m_wr_ack / m_wr_err  out  NUM_CPU  per-master completions.
- m_rd_data  out  NUM_CPU*DATA_WIDTH  per-master read data.
- d_req, d_req_is_wr, d_addr, d_wr_data, d_wr_biten  out  device request fields, same widths as one master.
- d_req_stall_wr, d_req_stall_rd, d_rd_ack, d_rd_err, d_rd_data, d_wr_ack, d_wr_err  in  device responses.
- spurious_ack  out  1  sticky flag: an ack arrived with nothing in flight.

## Operation
Request hold rule:
- A master holds req and all its fields constant while its stall for that request type is high.

Arbitration (combinational):
- Among masters with req=1, choose the first one at or after rr_ptr, modulo NUM_CPU.
- Drive that master's fields onto the d_* request signals.
- d_req = any request pending AND FIFO not full.

Accept:
- Accept occurs when d_req=1 and the device stall for the request type (wr or rd) is 0.
- On accept: push {master id, is_wr} into the ID FIFO and set rr_ptr = granted id + 1, wrapping to 0 after NUM_CPU-1.

Stalls:
- A requesting master's stall is 0 only in the cycle its request is accepted.
- All other requesting masters see stall=1.
- Stall outputs for masters that are not requesting are don't-care and are driven 1.

Completion:
- d_rd_ack or d_wr_ack pops the FIFO head.
- The ack, err and rd_data are forwarded combinationally to the head master only.
- m_rd_data of every other master is 0.

Ordering and boundaries:
- The device completes transactions strictly in order, with at most one ack per cycle.
- Push and pop may occur in the same cycle, including when the FIFO is full: the pop frees the slot first, so the accept is allowed.
- Ack with an empty FIFO: the ack is discarded and spurious_ack is set. spurious_ack clears only on reset.
- Ack type mismatch with the head's is_wr: forward the ack type the device gave, still to the head master, and pop.

Reset (asynchronous, active-low):
- Clears the FIFO, rr_ptr=0, spurious_ack=0 and the timeout state.
- Every master stall output = 1, every ack/err output = 0, d_req = 0.
- Transactions in flight when reset asserts are lost. Acks that arrive after reset deasserts take the spurious path.

## Timing
- Request path: zero latency. The cycle a master is accepted is the cycle d_req is presented.
- Ack path: zero latency, combinational from d_* acks to m_* acks.
- A master may issue a new request in the cycle after its accept.
- Back-to-back accepts are sustained at 1 per cycle until OUTSTANDING requests are in flight.
- Fairness: a continuously requesting master is accepted within NUM_CPU accepts.

## Configuration
CPU_IF_ARB_TIMEOUT_EN:
- When defined, a counter runs while the FIFO is non-empty and resets on each pop.
- If the counter reaches TIMEOUT_CYCLES, the arbiter pops the head and sends the head master m_rd_err or m_wr_err (chosen by the stored is_wr) together with the matching ack, with rd_data=0.
- It also increments drop_cnt, width clog2(OUTSTANDING+1). While drop_cnt>0, device acks are discarded and each one decrements drop_cnt.
- When undefined, there is no counter: the arbiter waits forever for an ack and drop_cnt does not exist.

## Structure
- Package cpu_if_arb_pkg holds the FIFO entry struct {id, is_wr}, the ID width constant $clog2(NUM_CPU) (min 1) and a round-robin pick function.
- Sub-module cpu_if_arb_fifo: a synchronous ID FIFO with push/pop/full/empty that allows same-cycle push and pop when full.

## Test plan
- NUM_CPU=2, only m1 issues rd 0x0010, device acks with data 0xBEEF -> m1 rd_ack=1, data 0xBEEF; m0 sees no ack and data 0.
- Both masters request every cycle, device never stalls -> accepts alternate m0,m1,m0,m1; acks route to the matching master.
- OUTSTANDING=2, device withholds acks -> third request stalls. An ack together with a new request in the same cycle -> pop and push both happen; the FIFO stays at 2.
- Device rd_ack arrives with nothing in flight -> no master ack; spurious_ack=1 until reset.
- With CPU_IF_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: write from m0, no ack -> m0 wr_ack=1 and wr_err=1 at cycle 8; the late device ack is discarded.
- Reset pulsed with 2 transactions in flight -> all outputs at reset values. After release, the FIFO is empty and a new request is accepted in the first cycle.
